// File: rtl/nibble_shift_feeder.sv
// nibble_shift_feeder
// Buffers 4-bit words from a valid/ready upstream in a small FIFO and feeds
// them to a 4-bit load/shift-left register. Each word is loaded once and then
// held for four cycles, so the register shifts it out MSB-first at pout[3].
// bit_valid and bit_last are timed to match the register's MSB output, so the
// consumer needs no bit counter of its own.
module nibble_shift_feeder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,        // asynchronous, active-low
    input  logic                     in_valid,
    input  logic [3:0]               in_data,
    output logic                     in_ready,
    output logic                     ld,
    output logic [3:0]               pin,
    output logic                     bit_valid,
    output logic                     bit_last,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Load/shift sequencer states. Each word spends one cycle in each state,
    // which gives a load period of four cycles.
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] SH1  = 3'd2;
    localparam logic [2:0] SH2  = 3'd3;
    localparam logic [2:0] SH3  = 3'd4;

    logic [3:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [2:0]    state;
    logic [2:0]    state_nxt;

    logic          have_word;
    logic          push;
    logic          pop;
    logic          bit_valid_nxt;
    logic          bit_last_nxt;
    logic          busy_nxt;

    // FIFO status. Full refuses a push even when a pop happens on the same
    // edge, so in_ready depends on the registered count only.
    assign have_word  = (count != '0);
    assign in_ready   = rst && (count < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_count = count;

    // The head word leaves the FIFO on exactly the edge that enters LOAD.
    assign pop = (state_nxt == LOAD);

    // Next-state logic for the load/shift sequencer.
    always_comb begin
        // NOTE: the default assignment on entry keeps every path assigned,
        // so no latch is inferred for state_nxt.
        state_nxt = state;
        case (state)
            IDLE:    if (have_word) state_nxt = LOAD;
            LOAD:    state_nxt = SH1;
            SH1:     state_nxt = SH2;
            SH2:     state_nxt = SH3;
            SH3:     state_nxt = have_word ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit strobes for the cycle after this edge. The register holds the MSB
    // of a word the cycle after LOAD, so pout[3] carries data while the
    // sequencer sits in SH1..SH3 and for the one cycle after SH3.
    always_comb begin
        bit_valid_nxt = (state_nxt == SH1) || (state_nxt == SH2) ||
                        (state_nxt == SH3) || (state == SH3);
        bit_last_nxt  = (state == SH3);
        busy_nxt      = (state_nxt != IDLE) || bit_valid_nxt;
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately left out of reset; the
        // pointers and count define which entries are meaningful, so stale
        // contents are never observed and the array can map to plain RAM.
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples values from before the edge.
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Register-side outputs: load strobe and the word presented on pin.
    // pin keeps the last popped word until the next pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld  <= 1'b0;
            pin <= 4'h0;
        end else begin
            ld <= pop;
            if (pop) begin
                pin <= mem[rd_ptr];
            end
        end
    end

    // Consumer-side strobes aligned with the register's MSB output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bit_valid <= bit_valid_nxt;
            bit_last  <= bit_last_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule
